// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush
// and an optional second (skid) entry that registers in_ready.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH       = 32,
    parameter bit               SKID        = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Encoding equals the entry count, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_acc;
    logic             w_pop;

    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main;
    assign occupancy = 2'(r_state);

    generate
        if (SKID) begin : g_skid
            assign in_ready = (r_state != ST_TWO);
        end else begin : g_single
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    assign w_acc = in_valid && in_ready;
    assign w_pop = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_main_nxt  = in_data;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_pop && w_acc) begin
                        w_main_nxt = in_data;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_acc && SKID) begin
                        // Downstream stalled: park the new payload behind M.
                        w_skid_nxt  = in_data;
                        w_state_nxt = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= RESET_VALUE;
            r_skid  <= RESET_VALUE;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a queue scoreboard
// on a SKID=1 (8-bit) and a SKID=0 (64-bit) instance sharing stimulus.
module tb_pipe_stage_reg;

    localparam logic [7:0]  RV_S = 8'hA5;
    localparam logic [63:0] RV_N = 64'hDEAD_BEEF_0123_4567;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;

    logic        s_in_ready, s_out_valid;
    logic [7:0]  s_out_data;
    logic [1:0]  s_occ;
    logic        n_in_ready, n_out_valid;
    logic [63:0] n_out_data;
    logic [1:0]  n_occ;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  q_s[$];
    logic [63:0] q_n[$];
    bit          exp_s_rdy, exp_n_rdy;
    bit          s_acc, s_pop, n_acc, n_pop;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(8), .SKID(1'b1), .RESET_VALUE(RV_S)) u_s (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_data   (in_data[7:0]),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .out_data  (s_out_data),
        .occupancy (s_occ)
    );

    pipe_stage_reg #(.WIDTH(64), .SKID(1'b0), .RESET_VALUE(RV_N)) u_n (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (n_in_ready),
        .in_data   (in_data),
        .out_valid (n_out_valid),
        .out_ready (out_ready),
        .out_data  (n_out_data),
        .occupancy (n_occ)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: the reference is an in-order queue of accepted payloads.
    always @(negedge clk) begin
        if (rst) begin
            q_s.delete();
            q_n.delete();
        end
        exp_s_rdy = (q_s.size() != 2);
        exp_n_rdy = (q_n.size() == 0) || out_ready;
        chk("sb_s_valid", s_out_valid, q_s.size() != 0);
        chk("sb_s_occ", s_occ, 64'(q_s.size()));
        chk("sb_s_rdy", s_in_ready, exp_s_rdy);
        chk("sb_n_valid", n_out_valid, q_n.size() != 0);
        chk("sb_n_occ", n_occ, 64'(q_n.size()));
        chk("sb_n_rdy", n_in_ready, exp_n_rdy);
        if (q_s.size() != 0) chk("sb_s_data", s_out_data, q_s[0]);
        if (q_n.size() != 0) chk("sb_n_data", n_out_data, q_n[0]);
        if (!rst) begin
            if (flush) begin
                q_s.delete();
                q_n.delete();
            end else begin
                s_pop = (q_s.size() != 0) && out_ready;
                s_acc = in_valid && exp_s_rdy;
                n_pop = (q_n.size() != 0) && out_ready;
                n_acc = in_valid && exp_n_rdy;
                if (s_pop) void'(q_s.pop_front());
                if (s_acc) q_s.push_back(in_data[7:0]);
                if (n_pop) void'(q_n.pop_front());
                if (n_acc) q_n.push_back(in_data);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        #1;
        chk("rst_s_valid", s_out_valid, 0);
        chk("rst_s_occ", s_occ, 0);
        chk("rst_s_data", s_out_data, RV_S);
        chk("rst_s_rdy", s_in_ready, 1);
        chk("rst_n_data", n_out_data, RV_N);
        chk("rst_n_rdy", n_in_ready, 1);
        tick();
        tick();
        rst = 1'b0;

        // Streaming at full throughput
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h1;
        tick();
        chk("str1_s", s_out_data, 8'h1);
        chk("str1_n", n_out_data, 64'h1);
        chk("str1_rdy", s_in_ready, 1);
        in_data = 64'h2;
        tick();
        chk("str2_s", s_out_data, 8'h2);
        chk("str2_n", n_out_data, 64'h2);
        chk("str2_rdy", s_in_ready, 1);
        in_data = 64'h3;
        tick();
        chk("str3_s", s_out_data, 8'h3);
        chk("str3_n", n_out_data, 64'h3);
        chk("str3_v", s_out_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("str_drain", s_out_valid, 0);

        // Skid: A held, B parked behind it
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        tick();
        chk("skd_a_occ", s_occ, 1);
        chk("skd_n_rdy", n_in_ready, 0);
        in_data = 64'hB;
        tick();
        chk("skd_occ2", s_occ, 2);
        chk("skd_rdy0", s_in_ready, 0);
        chk("skd_data_a", s_out_data, 8'hA);
        chk("skd_n_occ", n_occ, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("skd_n_rdy1", n_in_ready, 1);
        tick();
        chk("skd_data_b", s_out_data, 8'hB);
        chk("skd_rdy1", s_in_ready, 1);
        chk("skd_n_empty", n_occ, 0);
        tick();
        chk("skd_empty", s_occ, 0);

        // Stall on the single-entry instance
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h55;
        tick();
        in_data = 64'h66;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stl_n_data", n_out_data, 64'h55);
            chk("stl_n_rdy", n_in_ready, 0);
            chk("stl_n_occ", n_occ, 1);
            chk("stl_s_data", s_out_data, 8'h55);
            chk("stl_s_occ", s_occ, 2);
        end

        // Flush with a payload offered in the same cycle
        flush   = 1'b1;
        in_data = 64'h77;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_s_valid", s_out_valid, 0);
        chk("fl_s_occ", s_occ, 0);
        chk("fl_n_valid", n_out_valid, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no77", s_out_valid, 0);
        end

        // Async reset mid-cycle while two entries are held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h11;
        tick();
        in_data = 64'h22;
        tick();
        in_valid = 1'b0;
        chk("ar_pre_occ", s_occ, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_s_valid", s_out_valid, 0);
        chk("ar_s_occ", s_occ, 0);
        chk("ar_s_data", s_out_data, RV_S);
        chk("ar_s_rdy", s_in_ready, 1);
        chk("ar_n_data", n_out_data, RV_N);
        chk("ar_n_valid", n_out_valid, 0);
        tick();
        rst = 1'b0;

        // Random traffic, first mostly flowing then mostly stalled
        for (int i = 0; i < 6000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (i < 3000) ? ($urandom_range(0, 3) != 0)
                                   : ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_data   = {$urandom, $urandom};
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("end_s_occ", s_occ, 0);
        chk("end_n_occ", n_occ, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
